// File: rtl/serv_pkg.sv
// Shared types for the SERV sequencing controller: FSM state encoding and
// counter sizing helpers that depend on the datapath width W.
package serv_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    INIT   = 3'd2,
    WAIT   = 3'd3,
    ARM    = 3'd4,
    RUN    = 3'd5
  } state_t;

  localparam int CNT_WIDTH = 5;

  function automatic int cnt_chunks(input int w);
    return 32 / w;
  endfunction

  function automatic int cnt_bits(input int w);
    return $clog2(32 / w);
  endfunction

  function automatic bit legal_w(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

endpackage

// File: rtl/serv_seq_ctrl_if.sv
// Bus and register-file handshakes between the sequencer (master) and the
// ibus/dbus/RF/MDU side (slave); requests are level signals held until acked.
interface serv_seq_ctrl_if;
  logic ibus_cyc;
  logic ibus_ack;
  logic dbus_cyc;
  logic dbus_ack;
  logic rf_rreq;
  logic rf_wreq;
  logic rf_ready;
  logic mdu_valid;
  logic mdu_ready;

  modport master (
    output ibus_cyc, dbus_cyc, rf_rreq, rf_wreq, mdu_valid,
    input  ibus_ack, dbus_ack, rf_ready, mdu_ready
  );

  modport slave (
    input  ibus_cyc, dbus_cyc, rf_rreq, rf_wreq, mdu_valid,
    output ibus_ack, dbus_ack, rf_ready, mdu_ready
  );
endinterface

// File: rtl/serv_seq_cnt.sv
// Chunk counter: walks 32 bits in 32/W cycles while enabled, decodes are
// combinational off the chunk register; no backpressure, idles at zero.
module serv_seq_cnt
  import serv_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_cnt_done,
  output logic                 o_cnt0,
  output logic                 o_cnt0to3,
  output logic                 o_cnt12to31
);

  localparam int CNT_BITS = cnt_bits(W);
  localparam int SHIFT    = $clog2(W);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(cnt_chunks(W) - 1);

  logic [CNT_BITS-1:0] chunk_q;

  // Holding at zero whenever disabled means every INIT/RUN phase starts clean.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chunk_q <= '0;
    end else if (i_en) begin
      chunk_q <= chunk_q + CNT_BITS'(1);
    end else begin
      chunk_q <= '0;
    end
  end

  assign o_cnt       = CNT_WIDTH'(chunk_q) << SHIFT;
  assign o_cnt_done  = i_en & (chunk_q == LAST);
  assign o_cnt0      = i_en & (o_cnt == 5'd0);
  assign o_cnt0to3   = i_en & (o_cnt < 5'd4);
  assign o_cnt12to31 = i_en & (o_cnt >= 5'd12);

endmodule

// File: rtl/serv_seq_ctrl.sv
// Instruction lifecycle sequencer for the bit-serial core: 32/W cycles per
// counted phase; waits indefinitely on ibus/dbus/RF/MDU handshakes.
module serv_seq_ctrl
  import serv_pkg::*;
#(
  parameter int W        = 1,
  parameter bit WITH_CSR = 1'b1,
  parameter bit ALIGN    = 1'b0,
  parameter bit MDU      = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  serv_seq_ctrl_if.master        bus,
  input  logic                   i_two_stage_op,
  input  logic                   i_branch_op,
  input  logic                   i_cond_branch,
  input  logic                   i_bne_or_bge,
  input  logic                   i_shift_op,
  input  logic                   i_sh_done,
  input  logic                   i_slt_or_branch,
  input  logic                   i_dbus_en,
  input  logic                   i_mdu_op,
  input  logic                   i_e_op,
  input  logic                   i_alu_cmp,
  input  logic                   i_ctrl_misalign,
  input  logic                   i_mem_misalign,
  input  logic                   i_new_irq,
  output logic [2:0]             o_state,
  output logic [CNT_WIDTH-1:0]   o_cnt,
  output logic                   o_cnt_en,
  output logic                   o_cnt_done,
  output logic                   o_cnt0,
  output logic                   o_cnt0to3,
  output logic                   o_cnt12to31,
  output logic [1:0]             o_mem_bytecnt,
  output logic                   o_init,
  output logic                   o_ctrl_pc_en,
  output logic                   o_ctrl_jump,
  output logic                   o_ctrl_trap,
  output logic                   o_bufreg_en
);

  if (!legal_w(W)) begin : g_bad_w
    $error("serv_seq_ctrl: W must be 1, 2, 4 or 8");
  end

  state_t state_q;
  logic   trap_r;
  logic   jump_q;
  logic   take_branch;
  logic   trap_set;
  logic   wait_go;
  logic   mdu_req;

  assign take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
  assign trap_set    = WITH_CSR & ((take_branch & i_ctrl_misalign & !ALIGN) |
                                   (i_dbus_en & i_mem_misalign));
  assign mdu_req     = MDU & i_mdu_op;
  // A pending trap skips the memory/MDU access and only re-reads the RF.
  assign wait_go     = (state_q == WAIT) & !trap_r;

  assign bus.ibus_cyc  = (state_q == FETCH) & i_rst_n;
  assign bus.rf_rreq   = (bus.ibus_cyc & bus.ibus_ack) | ((state_q == WAIT) & trap_r);
  assign bus.dbus_cyc  = wait_go & i_dbus_en;
  assign bus.mdu_valid = wait_go & mdu_req;
  assign bus.rf_wreq   = wait_go & (bus.dbus_ack | (i_shift_op & i_sh_done) |
                                    i_slt_or_branch | (mdu_req & bus.mdu_ready));

  assign o_state       = state_q;
  assign o_cnt_en      = (state_q == INIT) | (state_q == RUN);
  assign o_mem_bytecnt = o_cnt[4:3];
  assign o_init        = (state_q == INIT);
  assign o_ctrl_pc_en  = (state_q == RUN);
  assign o_ctrl_jump   = jump_q;
  assign o_ctrl_trap   = i_rst_n & WITH_CSR & (i_e_op | i_new_irq | trap_r);
  assign o_bufreg_en   = (state_q == INIT) |
                         ((state_q == RUN) & i_two_stage_op & (o_ctrl_trap | i_branch_op)) |
                         ((state_q == WAIT) & i_shift_op & !i_sh_done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FETCH;
      trap_r  <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: if (bus.ibus_ack) begin
          trap_r  <= 1'b0;
          jump_q  <= 1'b0;
          state_q <= DECODE;
        end
        DECODE: if (bus.rf_ready) begin
          state_q <= (i_two_stage_op & !i_new_irq) ? INIT : RUN;
        end
        INIT: if (o_cnt_done) begin
          jump_q  <= take_branch;
          trap_r  <= trap_set;
          state_q <= WAIT;
        end
        WAIT: if (trap_r | bus.rf_wreq) begin
          state_q <= ARM;
        end
        ARM: if (bus.rf_ready) begin
          state_q <= RUN;
        end
        RUN: if (o_cnt_done) begin
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  serv_seq_cnt #(.W(W)) u_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (o_cnt_en),
    .o_cnt       (o_cnt),
    .o_cnt_done  (o_cnt_done),
    .o_cnt0      (o_cnt0),
    .o_cnt0to3   (o_cnt0to3),
    .o_cnt12to31 (o_cnt12to31)
  );

endmodule

// File: tb/tb_serv_seq_ctrl.sv
// Scoreboard bench for serv_seq_ctrl (W=2, MDU on): directed instructions push
// expected handshake/phase-end events; a negedge monitor pops and compares.
module tb_serv_seq_ctrl;
  import serv_pkg::*;

  localparam int W     = 2;
  localparam int PHASE = 32 / W;

  typedef struct packed {
    logic [2:0] st;
    logic       rreq;
    logic       wreq;
    logic       done;
    logic       dbus;
    logic       mdu;
    logic       jump;
    logic       trap;
    logic [4:0] cnt;
    logic [5:0] len;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_two_stage_op, i_branch_op, i_cond_branch, i_bne_or_bge, i_shift_op;
  logic i_sh_done, i_slt_or_branch, i_dbus_en, i_mdu_op, i_e_op;
  logic i_alu_cmp, i_ctrl_misalign, i_mem_misalign, i_new_irq;
  logic [2:0] o_state;
  logic [4:0] o_cnt;
  logic [1:0] o_mem_bytecnt;
  logic o_cnt_en, o_cnt_done, o_cnt0, o_cnt0to3, o_cnt12to31;
  logic o_init, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_bufreg_en;

  serv_seq_ctrl_if bus ();

  serv_seq_ctrl #(.W(W), .WITH_CSR(1'b1), .ALIGN(1'b0), .MDU(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus),
    .i_two_stage_op(i_two_stage_op), .i_branch_op(i_branch_op),
    .i_cond_branch(i_cond_branch), .i_bne_or_bge(i_bne_or_bge),
    .i_shift_op(i_shift_op), .i_sh_done(i_sh_done),
    .i_slt_or_branch(i_slt_or_branch), .i_dbus_en(i_dbus_en),
    .i_mdu_op(i_mdu_op), .i_e_op(i_e_op), .i_alu_cmp(i_alu_cmp),
    .i_ctrl_misalign(i_ctrl_misalign), .i_mem_misalign(i_mem_misalign),
    .i_new_irq(i_new_irq), .o_state(o_state), .o_cnt(o_cnt),
    .o_cnt_en(o_cnt_en), .o_cnt_done(o_cnt_done), .o_cnt0(o_cnt0),
    .o_cnt0to3(o_cnt0to3), .o_cnt12to31(o_cnt12to31),
    .o_mem_bytecnt(o_mem_bytecnt), .o_init(o_init),
    .o_ctrl_pc_en(o_ctrl_pc_en), .o_ctrl_jump(o_ctrl_jump),
    .o_ctrl_trap(o_ctrl_trap), .o_bufreg_en(o_bufreg_en)
  );

  always #5 i_clk = ~i_clk;

  ev_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;
  int  run_len = 0;

  task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [2:0] st, input logic rreq, input logic wreq,
                             input logic done, input logic dbus, input logic mdu,
                             input logic jump, input logic trap,
                             input logic [4:0] cnt, input logic [5:0] len);
    ev_t e;
    e.st = st; e.rreq = rreq; e.wreq = wreq; e.done = done; e.dbus = dbus;
    e.mdu = mdu; e.jump = jump; e.trap = trap; e.cnt = cnt; e.len = len;
    return e;
  endfunction

  // FETCH still shows the previous instruction's jump/trap until the ack edge.
  task automatic exp_fetch(input logic j, input logic t);
    exp_q.push_back(mk(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, j, t, 5'd0, 6'd0));
  endtask

  task automatic exp_done(input logic [2:0] st, input logic j, input logic t);
    exp_q.push_back(mk(st, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, j, t, 5'(32 - W), 6'(PHASE)));
  endtask

  task automatic exp_wait(input logic rreq, input logic wreq, input logic dbus,
                          input logic mdu, input logic j, input logic t);
    exp_q.push_back(mk(WAIT, rreq, wreq, 1'b0, dbus, mdu, j, t, 5'd0, 6'd0));
  endtask

  always @(negedge i_clk) begin : monitor
    ev_t obs;
    ev_t want;
    logic [4:0] ec;
    if (o_cnt_en) begin
      run_len++;
      ec = 5'((run_len - 1) * W);
      check_vec("cnt_decode", 64'({o_cnt, o_cnt0, o_cnt0to3, o_cnt12to31, o_mem_bytecnt}),
                64'({ec, ec == 5'd0, ec < 5'd4, ec >= 5'd12, ec[4:3]}));
    end else begin
      run_len = 0;
    end
    if (bus.rf_rreq || bus.rf_wreq || o_cnt_done) begin
      obs = mk(o_state, bus.rf_rreq, bus.rf_wreq, o_cnt_done, bus.dbus_cyc,
               bus.mdu_valid, o_ctrl_jump, o_ctrl_trap, o_cnt, 6'(run_len));
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: got 0x%0h, want no event", obs);
      end else begin
        want = exp_q.pop_front();
        check_vec("event", 64'(obs), 64'(want));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (o_state != s && n < budget) begin
      step();
      n++;
    end
    check_vec(tag, 64'(o_state), 64'(s));
  endtask

  task automatic clear_dec();
    i_two_stage_op = 0; i_branch_op = 0; i_cond_branch = 0; i_bne_or_bge = 0;
    i_shift_op = 0; i_sh_done = 0; i_slt_or_branch = 0; i_dbus_en = 0;
    i_mdu_op = 0; i_e_op = 0; i_alu_cmp = 0; i_ctrl_misalign = 0;
    i_mem_misalign = 0; i_new_irq = 0;
  endtask

  task automatic issue();
    bus.ibus_ack = 1'b1;
    step();
    bus.ibus_ack = 1'b0;
    bus.rf_ready = 1'b1;
    step();
    bus.rf_ready = 1'b0;
  endtask

  task automatic finish_two(input string tag);
    wait_state(ARM, 3 * PHASE, tag);
    bus.rf_ready = 1'b1;
    step();
    bus.rf_ready = 1'b0;
    wait_state(FETCH, 3 * PHASE, tag);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_state, o_cnt, o_cnt_en, o_cnt_done, o_cnt0, o_cnt0to3, o_cnt12to31,
                o_mem_bytecnt, o_init, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_bufreg_en,
                bus.ibus_cyc, bus.dbus_cyc, bus.rf_rreq, bus.rf_wreq, bus.mdu_valid});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared + 1, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_dec();
    bus.ibus_ack = 0; bus.dbus_ack = 0; bus.rf_ready = 0; bus.mdu_ready = 0;
    repeat (3) step();
    check_vec("reset_outputs", 64'(all_outs()), 64'd0);
    i_rst_n = 1'b1;
    #1;
    check_vec("release", 64'({o_state, bus.ibus_cyc, o_cnt}), 64'({FETCH, 1'b1, 5'd0}));

    // ADDI: one-stage, DECODE straight to RUN
    exp_fetch(1'b0, 1'b0); exp_done(RUN, 1'b0, 1'b0);
    issue();
    wait_state(FETCH, 3 * PHASE, "addi_end");
    check_vec("addi_ibus_next", 64'(bus.ibus_cyc), 64'd1);

    // LW aligned: dbus held until ack
    i_two_stage_op = 1; i_dbus_en = 1;
    exp_fetch(1'b0, 1'b0); exp_done(INIT, 1'b0, 1'b0);
    exp_wait(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); exp_done(RUN, 1'b0, 1'b0);
    issue();
    wait_state(WAIT, 3 * PHASE, "lw_wait");
    for (int i = 0; i < 3; i++) begin
      check_vec("lw_hold", 64'({bus.dbus_cyc, bus.rf_wreq}), 64'(2'b10));
      step();
    end
    bus.dbus_ack = 1; step(); bus.dbus_ack = 0;
    finish_two("lw_end");
    clear_dec();

    // JAL to misaligned target: jump and trap latched, WAIT only re-reads RF
    i_two_stage_op = 1; i_branch_op = 1; i_ctrl_misalign = 1;
    exp_fetch(1'b0, 1'b0); exp_done(INIT, 1'b0, 1'b0);
    exp_wait(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); exp_done(RUN, 1'b1, 1'b1);
    issue();
    finish_two("jal_end");
    clear_dec();

    // MUL: mdu_valid held 10 idle cycles, then mdu_ready with a stray dbus_ack
    i_two_stage_op = 1; i_mdu_op = 1;
    exp_fetch(1'b1, 1'b1); exp_done(INIT, 1'b0, 1'b0);
    exp_wait(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); exp_done(RUN, 1'b0, 1'b0);
    issue();
    wait_state(WAIT, 3 * PHASE, "mul_wait");
    for (int i = 0; i < 10; i++) begin
      check_vec("mul_hold", 64'({bus.mdu_valid, bus.rf_wreq}), 64'(2'b10));
      step();
    end
    bus.mdu_ready = 1; bus.dbus_ack = 1; step(); bus.mdu_ready = 0; bus.dbus_ack = 0;
    check_vec("mul_single_step", 64'(o_state), 64'(ARM));
    finish_two("mul_end");
    clear_dec();

    // BNE with equal operands: not taken
    i_two_stage_op = 1; i_branch_op = 1; i_cond_branch = 1; i_bne_or_bge = 1;
    i_alu_cmp = 1; i_slt_or_branch = 1;
    exp_fetch(1'b0, 1'b0); exp_done(INIT, 1'b0, 1'b0);
    exp_wait(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); exp_done(RUN, 1'b0, 1'b0);
    issue();
    finish_two("bne_end");

    // BEQ with equal operands: taken
    i_bne_or_bge = 0;
    exp_fetch(1'b0, 1'b0); exp_done(INIT, 1'b0, 1'b0);
    exp_wait(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); exp_done(RUN, 1'b1, 1'b0);
    issue();
    finish_two("beq_end");
    clear_dec();

    // IRQ during DECODE of a two-stage op: one-stage RUN with trap
    i_two_stage_op = 1;
    exp_fetch(1'b1, 1'b0); exp_done(RUN, 1'b0, 1'b1);
    bus.ibus_ack = 1; step(); bus.ibus_ack = 0;
    i_new_irq = 1; bus.rf_ready = 1; step(); bus.rf_ready = 0;
    wait_state(FETCH, 3 * PHASE, "irq_end");
    clear_dec();

    // Reset in RUN cycle 5 aborts everything asynchronously
    exp_fetch(1'b0, 1'b0);
    issue();
    repeat (4) step();
    check_vec("pre_reset_cnt", 64'(o_cnt), 64'(4 * W));
    i_rst_n = 1'b0;
    #1;
    check_vec("async_reset_outputs", 64'(all_outs()), 64'd0);
    repeat (2) step();
    i_rst_n = 1'b1;
    #1;
    check_vec("post_reset", 64'({o_state, bus.ibus_cyc, o_cnt}), 64'({FETCH, 1'b1, 5'd0}));

    exp_fetch(1'b0, 1'b0); exp_done(RUN, 1'b0, 1'b0);
    issue();
    wait_state(FETCH, 3 * PHASE, "recover_end");

    repeat (3) step();
    check_vec("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
